// File: rtl/mem_refill_ctl_if.sv
// Memory-bus bundle between the refill controller and the memory side.
// The controller issues one word-sized beat per request. Read data comes
// back on its own valid strobe some time after the request is accepted.
interface mem_refill_ctl_if #(
  parameter int ADDR_W = 32
) ();
  logic              o_mem_req_valid;
  logic              i_mem_req_ready;
  logic              o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [31:0]       o_mem_wdata;
  logic              i_mem_rdata_valid;
  logic [31:0]       i_mem_rdata;

  modport master (
    output o_mem_req_valid,
    output o_mem_we,
    output o_mem_addr,
    output o_mem_wdata,
    input  i_mem_req_ready,
    input  i_mem_rdata_valid,
    input  i_mem_rdata
  );

  modport slave (
    input  o_mem_req_valid,
    input  o_mem_we,
    input  o_mem_addr,
    input  o_mem_wdata,
    output i_mem_req_ready,
    output i_mem_rdata_valid,
    output i_mem_rdata
  );
endinterface

// File: rtl/mem_refill_ctl.sv
// Data-cache refill controller. On a miss it optionally writes back the
// dirty victim line, one beat at a time. It then reads the missing line
// one beat at a time and presents the whole line with a one-cycle
// response pulse.
module mem_refill_ctl #(
  parameter int ADDR_W     = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_miss_req,
  input  logic [ADDR_W-1:0]       i_miss_addr,
  input  logic                    i_wb_dirty,
  input  logic [ADDR_W-1:0]       i_wb_addr,
  input  logic [32*LINE_WORDS-1:0] i_wb_line,
  output logic                    o_busy,
  output logic [32*LINE_WORDS-1:0] o_memory_line,
  output logic                    o_memory_response,
  mem_refill_ctl_if.master        mem
);
  localparam int CNT_W  = $clog2(LINE_WORDS);
  localparam int LINE_W = 32 * LINE_WORDS;
  localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'(LINE_WORDS * 4 - 1);
  localparam logic [CNT_W-1:0]  LAST_BEAT   = CNT_W'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    WB_REQ,
    RD_REQ,
    RD_WAIT,
    RESP
  } state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  beat, beat_next;
  logic [ADDR_W-1:0] miss_base;
  logic [ADDR_W-1:0] wb_base;
  logic [LINE_W-1:0] wb_line;
  logic              capture;
  logic              store_word;
  logic [ADDR_W-1:0] beat_offset;

  // The byte offset of beat k within the line is 4k. Both line bases are
  // aligned, so adding this offset never carries into the tag bits.
  assign beat_offset = ADDR_W'({beat, 2'b00});

  // State register and beat counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      beat  <= '0;
    end else begin
      state <= state_next;
      beat  <= beat_next;
    end
  end

  // Snapshot the request once in IDLE, so that later input changes cannot disturb the transaction
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      miss_base <= '0;
      wb_base   <= '0;
      wb_line   <= '0;
    end else if (capture) begin
      miss_base <= i_miss_addr & ~OFFSET_MASK;
      wb_base   <= i_wb_addr & ~OFFSET_MASK;
      wb_line   <= i_wb_line;
    end
  end

  // Refill line assembly; a word is only overwritten when its read data arrives
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_memory_line <= '0;
    end else if (store_word) begin
      o_memory_line[{beat, 5'b00000} +: 32] <= mem.i_mem_rdata;
    end
  end

  // Next-state and bus outputs; the outputs depend only on the registered state, so they stay stable during a stall
  always_comb begin
    state_next            = state;
    beat_next             = beat;
    capture               = 1'b0;
    store_word            = 1'b0;
    o_busy                = 1'b1;
    o_memory_response     = 1'b0;
    mem.o_mem_req_valid   = 1'b0;
    mem.o_mem_we          = 1'b0;
    mem.o_mem_addr        = '0;
    mem.o_mem_wdata       = '0;
    case (state)
      IDLE: begin
        o_busy = 1'b0;
        if (i_miss_req) begin
          capture    = 1'b1;
          beat_next  = '0;
          state_next = i_wb_dirty ? WB_REQ : RD_REQ;
        end
      end
      WB_REQ: begin
        mem.o_mem_req_valid = 1'b1;
        mem.o_mem_we        = 1'b1;
        mem.o_mem_addr      = wb_base + beat_offset;
        mem.o_mem_wdata     = wb_line[{beat, 5'b00000} +: 32];
        if (mem.i_mem_req_ready) begin
          beat_next = beat + CNT_W'(1);
          if (beat == LAST_BEAT) begin
            state_next = RD_REQ;
          end
        end
      end
      RD_REQ: begin
        mem.o_mem_req_valid = 1'b1;
        mem.o_mem_addr      = miss_base + beat_offset;
        if (mem.i_mem_req_ready) begin
          state_next = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (mem.i_mem_rdata_valid) begin
          store_word = 1'b1;
          beat_next  = beat + CNT_W'(1);
          state_next = (beat == LAST_BEAT) ? RESP : RD_REQ;
        end
      end
      RESP: begin
        o_memory_response = 1'b1;
        state_next        = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end
endmodule

// File: doc/mem_refill_ctl.md
MEM_REFILL_CTL -- requirements
Module: mem_refill_ctl

Interface
REQ-001 Parameter: ADDR_W, 32, byte address width.
REQ-002 Parameter: LINE_WORDS, 4, 32-bit words per cache line; power of 2, at least 2.
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-low.
REQ-005 Port: i_miss_req  input  1  data-cache refill request; level, sampled only in IDLE.
REQ-006 Port: i_miss_addr  input  ADDR_W  miss byte address.
REQ-007 Port: i_wb_dirty  input  1  victim line is dirty; write-back precedes refill.
REQ-008 Port: i_wb_addr  input  ADDR_W  victim line byte address.
REQ-009 Port: i_wb_line  input  32*LINE_WORDS  victim data; word k at bits [32k+31:32k].
REQ-010 Port: o_busy  output  1  high in every state except IDLE.
REQ-011 Port: o_memory_line  output  32*LINE_WORDS  refilled line; same word packing as i_wb_line.
REQ-012 Port: o_memory_response  output  1  one-cycle pulse; o_memory_line is valid.
REQ-013 Port: o_mem_req_valid  output  1  memory-bus request valid.
REQ-014 Port: i_mem_req_ready  input  1  memory accepts the request.
REQ-015 Port: o_mem_we  output  1  1 = write beat, 0 = read beat.
REQ-016 Port: o_mem_addr  output  ADDR_W  word-aligned beat address.
REQ-017 Port: o_mem_wdata  output  32  write-beat data.
REQ-018 Port: i_mem_rdata_valid  input  1  read data returned.
REQ-019 Port: i_mem_rdata  input  32  read data.

Function
REQ-020 States SHALL be IDLE, WB_REQ, RD_REQ, RD_WAIT and RESP, with a beat counter of width log2(LINE_WORDS).
REQ-021 Line base SHALL be the captured address with its low log2(LINE_WORDS)+2 bits cleared; beat k address = base + 4k.
REQ-022 In IDLE with i_miss_req=1: capture both addresses, i_wb_line and i_wb_dirty; clear the counter; go to WB_REQ if dirty, else RD_REQ.
REQ-023 WB_REQ: valid=1, we=1, addr=wb base+4k, wdata=captured word k; on valid&ready increment k; after the last beat clear k and go to RD_REQ.
REQ-024 RD_REQ: valid=1, we=0, addr=miss base+4k; on valid&ready go to RD_WAIT.
REQ-025 RD_WAIT: valid=0; on i_mem_rdata_valid store i_mem_rdata into line word k; if k=LINE_WORDS-1 go to RESP, else increment k and return to RD_REQ.
REQ-026 RESP: o_memory_response=1 for exactly one cycle, then IDLE; o_memory_line SHALL hold its value until the next refill's first stored word.
REQ-027 While o_mem_req_valid=1 and i_mem_req_ready=0, o_mem_addr, o_mem_we and o_mem_wdata SHALL hold stable.
REQ-028 i_miss_req SHALL be ignored outside IDLE; input changes after capture SHALL have no effect.
REQ-029 i_mem_rdata_valid outside RD_WAIT SHALL be ignored.
REQ-030 The beat counter SHALL wrap from LINE_WORDS-1 to 0 at each phase end, with no overflow into other state.
REQ-031 Clean-miss latency with ready=1 and read data the cycle after acceptance: capture in cycle 0, response in cycle 2*LINE_WORDS+1 (cycle 9 at default).
REQ-032 A dirty miss SHALL add LINE_WORDS cycles with ready held at 1.

Reset
REQ-033 On rst=0, asynchronously: state=IDLE, counter=0, o_busy=0, o_memory_response=0, o_mem_req_valid=0, o_mem_we=0, o_mem_addr=0, o_mem_wdata=0, o_memory_line=0, captured registers=0.
REQ-034 Reset asserted mid-transaction SHALL abandon it with no response pulse; after release the block SHALL accept a new request from IDLE.

Verification
REQ-035 Clean miss at 0x0000_1234, ready=1, read data 0xA0..0xA3 one cycle after each acceptance -> read addresses 0x1230, 0x1234, 0x1238, 0x123C; response pulse in cycle 9; line = {0xA3,0xA2,0xA1,0xA0}.
REQ-036 Dirty miss with wb_addr 0x0000_2000 and line {4,3,2,1} -> write beats 0x2000=1, 0x2004=2, 0x2008=3, 0x200C=4, then 4 reads; response in cycle 13.
REQ-037 ready held at 0 for 3 cycles on beat 1 -> valid stays high; addr and wdata stay constant; exactly one acceptance per beat.
REQ-038 i_miss_req pulsed during RD_WAIT and a stray i_mem_rdata_valid in RD_REQ -> no new capture; line contents unaffected.
REQ-039 rst=0 during the third read beat -> all outputs 0 immediately; no response pulse; a new miss at 0x40 after release completes normally.
REQ-040 Back-to-back misses with i_miss_req held high -> second capture in the cycle after RESP; o_busy low for exactly that one cycle.
